pipe_latch_elastic: RTL and testbench

Parametrised elastic pipeline register that succeeds the fixed-width, single-entry stage latch between pipeline stages. It holds up to DEPTH entries of WIDTH bits in a circular buffer, moves them with a valid/ready handshake, and takes the same 2-bit stage control from the pipeline controller (run, hold, flush, drain). It sits between any two pipeline stages, for example EX/MEM, so that a multi-cycle memory stage can absorb results without stalling the upstream stage every cycle.

---
 rtl/pipe_latch_elastic_if.sv | 24 ++
 rtl/pipe_latch_elastic.sv | 86 ++++++++
 tb/tb_pipe_latch_elastic.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_latch_elastic_if.sv
// Handshake bundle for the elastic pipeline register: upstream push side and
// downstream pop side.
// Valid/ready: a beat transfers on a rising edge where valid & ready are both 1;
// valid never depends on ready, but in_ready may depend on out_ready.
interface pipe_latch_elastic_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/pipe_latch_elastic.sv
// Elastic pipeline register: DEPTH-entry circular buffer between two stages,
// steered by the 2-bit stage control (run, hold, flush, drain).
module pipe_latch_elastic #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           ctr,
  pipe_latch_elastic_if.slave  bus,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    HOLD  = 2'b01,
    FLUSH = 2'b10,
    DRAIN = 2'b11
  } mode_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  mode_t            mode;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             in_ready;
  logic             out_valid;
  logic             push;
  logic             pop;

  assign mode  = mode_t'(ctr);
  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);
  assign count = cnt;

  // Control is not registered: a mode change gates the handshake this cycle.
  // In RUN a full buffer still accepts when the head leaves in the same cycle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (mode)
      RUN: begin
        in_ready  = !full | bus.out_ready;
        out_valid = !empty;
      end
      DRAIN:   out_valid = !empty;
      default: ;
    endcase
  end

  assign push          = bus.in_valid & in_ready;
  assign pop           = out_valid & bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.data_out  = mem[rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mode == FLUSH) begin
      // Storage keeps its stale contents; only the bookkeeping is cleared.
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= bus.data_in;
        wp      <= (wp == LAST) ? '0 : wp + 1'b1;
      end
      if (pop) rp <= (rp == LAST) ? '0 : rp + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_latch_elastic.sv
// Bench for pipe_latch_elastic: directed scenarios plus a randomized run checked
// against a queue model of the buffer (DEPTH=4), and an async-reset case (DEPTH=3).
module tb_pipe_latch_elastic;

  logic       clk;
  logic       rst_a, rst_b;
  logic [1:0] ctr_a, ctr_b;
  logic [2:0] count_a;
  logic [1:0] count_b;
  logic       full_a, empty_a, full_b, empty_b;

  int errors = 0;
  int checks = 0;

  pipe_latch_elastic_if #(.WIDTH(32)) a_if ();
  pipe_latch_elastic_if #(.WIDTH(32)) b_if ();

  pipe_latch_elastic #(.WIDTH(32), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst_a), .ctr(ctr_a), .bus(a_if.slave),
    .count(count_a), .full(full_a), .empty(empty_a)
  );

  pipe_latch_elastic #(.WIDTH(32), .DEPTH(3)) dut_b (
    .clk(clk), .rst(rst_b), .ctr(ctr_b), .bus(b_if.slave),
    .count(count_b), .full(full_b), .empty(empty_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard: FIFO-order model of dut_a's contents
  logic [31:0] exp_q[$];
  bit m_push, m_pop;

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) exp_q.delete();
    else if (ctr_a == 2'b10) exp_q.delete();
    else begin
      m_pop  = (ctr_a == 2'b00 || ctr_a == 2'b11) && exp_q.size() != 0 && a_if.out_ready;
      m_push = (ctr_a == 2'b00) && (exp_q.size() < 4 || a_if.out_ready) && a_if.in_valid;
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(a_if.data_in);
    end
  end

  // drivers: inputs change on the falling edge, outputs sampled 1 time unit later
  task automatic drive_a(input logic [1:0] c, input logic iv, input logic [31:0] d,
                         input logic ordy);
    @(negedge clk);
    ctr_a = c; a_if.in_valid = iv; a_if.data_in = d; a_if.out_ready = ordy;
    #1;
  endtask

  task automatic drive_b(input logic [1:0] c, input logic iv, input logic [31:0] d,
                         input logic ordy);
    @(negedge clk);
    ctr_b = c; b_if.in_valid = iv; b_if.data_in = d; b_if.out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    ctr_a = 2'b00; a_if.in_valid = 0; a_if.data_in = 0; a_if.out_ready = 0;
    ctr_b = 2'b00; b_if.in_valid = 0; b_if.data_in = 0; b_if.out_ready = 0;
    rst_a = 0; rst_b = 0;
    #12;
    checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_a); end
    checks++; if (empty_a !== 1'b1 || full_a !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b want 1/0", empty_a, full_a); end
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_if.out_valid); end
    checks++; if (a_if.data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h want 0", a_if.data_out); end
    checks++; if (a_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_run: got %b want 1", a_if.in_ready); end
    ctr_a = 2'b01; #1;
    checks++; if (a_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_hold: got %b want 0", a_if.in_ready); end
    ctr_a = 2'b00;
    @(negedge clk); rst_a = 1; rst_b = 1;
  endtask

  task automatic test_fill();
    logic [31:0] d [4];
    d = '{32'h11, 32'h22, 32'h33, 32'h44};
    drive_a(2'b00, 1, d[0], 0);
    for (int i = 1; i < 4; i++) begin
      drive_a(2'b00, 1, d[i], 0);
      checks++; if (int'(count_a) !== i) begin errors++; $display("FAIL fill_count: got %0d want %0d", count_a, i); end
    end
    drive_a(2'b00, 0, 32'h0, 0);
    checks++; if (count_a !== 3'd4 || full_a !== 1'b1) begin errors++; $display("FAIL fill_full: got count=%0d full=%b want 4/1", count_a, full_a); end
    checks++; if (a_if.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", a_if.in_ready); end
    checks++; if (a_if.data_out !== 32'h11) begin errors++; $display("FAIL fill_head: got %h want 11", a_if.data_out); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rest [4];
    rest = '{32'h33, 32'h44, 32'h55, 32'h66};
    drive_a(2'b00, 1, 32'h55, 1);
    checks++; if (a_if.in_ready !== 1'b1 || a_if.data_out !== 32'h11) begin errors++; $display("FAIL stream_first: got ready=%b data=%h want 1/11", a_if.in_ready, a_if.data_out); end
    drive_a(2'b00, 1, 32'h66, 1);
    checks++; if (a_if.data_out !== 32'h22 || count_a !== 3'd4) begin errors++; $display("FAIL stream_second: got data=%h count=%0d want 22/4", a_if.data_out, count_a); end
    // pops continue across the pointer wrap
    for (int i = 0; i < 4; i++) begin
      drive_a(2'b00, 0, 32'h0, 1);
      checks++; if (a_if.out_valid !== 1'b1 || a_if.data_out !== rest[i]) begin errors++; $display("FAIL stream_wrap_%0d: got valid=%b data=%h want 1/%h", i, a_if.out_valid, a_if.data_out, rest[i]); end
    end
    drive_a(2'b00, 0, 32'h0, 0);
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL stream_empty: got %b want 1", empty_a); end
  endtask

  task automatic test_hold();
    drive_a(2'b00, 1, 32'hA0, 0);
    drive_a(2'b00, 1, 32'hA1, 0);
    for (int i = 0; i < 3; i++) begin
      drive_a(2'b01, 1, 32'hFF, 1);
      checks++; if (a_if.in_ready !== 1'b0 || a_if.out_valid !== 1'b0) begin errors++; $display("FAIL hold_hs: got ready=%b valid=%b want 0/0", a_if.in_ready, a_if.out_valid); end
      checks++; if (count_a !== 3'd2 || a_if.data_out !== 32'hA0) begin errors++; $display("FAIL hold_state: got count=%0d data=%h want 2/a0", count_a, a_if.data_out); end
    end
    drive_a(2'b00, 0, 32'h0, 1);
    checks++; if (a_if.out_valid !== 1'b1 || a_if.data_out !== 32'hA0) begin errors++; $display("FAIL hold_resume: got valid=%b data=%h want 1/a0", a_if.out_valid, a_if.data_out); end
    drive_a(2'b00, 0, 32'h0, 0);
    checks++; if (count_a !== 3'd1 || a_if.data_out !== 32'hA1) begin errors++; $display("FAIL hold_pop: got count=%0d data=%h want 1/a1", count_a, a_if.data_out); end
  endtask

  task automatic test_flush();
    drive_a(2'b00, 1, 32'hB1, 0);
    drive_a(2'b00, 1, 32'hB2, 0);
    drive_a(2'b10, 1, 32'hCC, 1);
    checks++; if (count_a !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", count_a); end
    checks++; if (a_if.in_ready !== 1'b0 || a_if.out_valid !== 1'b0) begin errors++; $display("FAIL flush_hs: got ready=%b valid=%b want 0/0", a_if.in_ready, a_if.out_valid); end
    drive_a(2'b00, 0, 32'h0, 0);
    checks++; if (count_a !== 3'd0 || empty_a !== 1'b1 || a_if.out_valid !== 1'b0) begin errors++; $display("FAIL flush_after: got count=%0d empty=%b valid=%b want 0/1/0", count_a, empty_a, a_if.out_valid); end
  endtask

  task automatic test_drain();
    drive_a(2'b00, 1, 32'h01, 0);
    drive_a(2'b00, 1, 32'h02, 0);
    drive_a(2'b11, 1, 32'hDEAD, 1);
    checks++; if (a_if.in_ready !== 1'b0 || a_if.out_valid !== 1'b1 || a_if.data_out !== 32'h01) begin errors++; $display("FAIL drain_first: got ready=%b valid=%b data=%h want 0/1/01", a_if.in_ready, a_if.out_valid, a_if.data_out); end
    drive_a(2'b11, 1, 32'hDEAD, 1);
    checks++; if (a_if.out_valid !== 1'b1 || a_if.data_out !== 32'h02 || count_a !== 3'd1) begin errors++; $display("FAIL drain_second: got valid=%b data=%h count=%0d want 1/02/1", a_if.out_valid, a_if.data_out, count_a); end
    drive_a(2'b11, 1, 32'hDEAD, 1);
    checks++; if (empty_a !== 1'b1 || count_a !== 3'd0 || a_if.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got empty=%b count=%0d valid=%b want 1/0/0", empty_a, count_a, a_if.out_valid); end
    drive_a(2'b00, 0, 32'h0, 0);
  endtask

  task automatic test_random();
    logic [1:0]  c;
    logic        iv, ordy;
    logic [31:0] d;
    int          r, sz;
    bit          exp_ir, exp_ov;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      c = (r < 12) ? 2'b00 : (r < 15) ? 2'b01 : (r < 16) ? 2'b10 : 2'b11;
      iv = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 3) != 0);
      d = $urandom;
      drive_a(c, iv, d, ordy);
      sz = exp_q.size();
      exp_ir = (c == 2'b00) && (sz < 4 || ordy);
      exp_ov = (c == 2'b00 || c == 2'b11) && sz != 0;
      checks++; if (a_if.in_ready !== exp_ir) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", n, a_if.in_ready, exp_ir); end
      checks++; if (a_if.out_valid !== exp_ov) begin errors++; $display("FAIL rand_out_valid[%0d]: got %b want %b", n, a_if.out_valid, exp_ov); end
      checks++; if (int'(count_a) !== sz || full_a !== (sz == 4) || empty_a !== (sz == 0)) begin errors++; $display("FAIL rand_count[%0d]: got count=%0d full=%b empty=%b want %0d", n, count_a, full_a, empty_a, sz); end
      if (sz != 0) begin
        checks++; if (a_if.data_out !== exp_q[0]) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", n, a_if.data_out, exp_q[0]); end
      end
    end
    drive_a(2'b00, 0, 32'h0, 0);
  endtask

  task automatic test_async_reset();
    drive_b(2'b00, 1, 32'h77, 0);
    drive_b(2'b00, 1, 32'h88, 0);
    drive_b(2'b00, 0, 32'h0, 0);
    checks++; if (count_b !== 2'd2 || b_if.data_out !== 32'h77) begin errors++; $display("FAIL areset_pre: got count=%0d data=%h want 2/77", count_b, b_if.data_out); end
    #2 rst_b = 0;
    #1;
    checks++; if (count_b !== 2'd0 || b_if.data_out !== 32'h0 || b_if.out_valid !== 1'b0 || empty_b !== 1'b1 || full_b !== 1'b0) begin errors++; $display("FAIL areset_now: got count=%0d data=%h valid=%b empty=%b full=%b want 0/0/0/1/0", count_b, b_if.data_out, b_if.out_valid, empty_b, full_b); end
    @(negedge clk); rst_b = 1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_hold();
    test_flush();
    test_drain();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
